// File: rtl/ccd_link_pkg.sv
// ccd_link_pkg: framing constants, packetizer states and packet-length helper.
// Optional macro CCD_FRAME_CHECKSUM_EN adds the checksum state and byte.
`timescale 1ns/1ps
package ccd_link_pkg;

    localparam logic [7:0] SYNC0   = 8'hAA;
    localparam logic [7:0] SYNC1   = 8'h55;
    localparam logic [7:0] TRAILER = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_LAT,
        ST_SEND,
        ST_PAD,
`ifdef CCD_FRAME_CHECKSUM_EN
        ST_CK,
`endif
        ST_TR
    } state_e;

    // Total bytes on the wire for one line of the given pixel count.
    function automatic int pkt_len(input int pixels);
`ifdef CCD_FRAME_CHECKSUM_EN
        return pixels + 7;
`else
        return pixels + 6;
`endif
    endfunction

endpackage

// File: rtl/ccd_frame_packetizer_slot.sv
// byte_tx_slot: one-byte output register for a valid/ready byte stream.
// A load overrides; otherwise the byte is held until it transfers.
`timescale 1ns/1ps
module byte_tx_slot (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid
);

    logic [7:0] data_q;
    logic [7:0] data_d;
    logic       valid_q;
    logic       valid_d;

    // Next slot contents: load wins, a transfer empties the slot.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = din;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/ccd_frame_packetizer.sv
// ccd_frame_packetizer: drains the CCD line FIFO into framed UART packets.
// Optional macro CCD_FRAME_CHECKSUM_EN adds the checksum byte before the trailer.
`timescale 1ns/1ps
module ccd_frame_packetizer
    import ccd_link_pkg::*;
#(
    parameter int PIXELS           = 1024,
    parameter int UNDERRUN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serialsend_flag,
    output logic       rdreq,
    input  logic [7:0] q,
    input  logic       rdempty,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int              TW       = $clog2(UNDERRUN_TIMEOUT + 1);
    localparam logic [15:0]     PIX_LEN  = 16'(PIXELS);
    localparam logic [15:0]     PIX_LAST = 16'(PIXELS - 1);
    localparam logic [TW-1:0]   TO_LAST  = TW'(UNDERRUN_TIMEOUT - 1);
`ifdef CCD_FRAME_CHECKSUM_EN
    localparam state_e          PAY_NEXT = ST_CK;
`else
    localparam state_e          PAY_NEXT = ST_TR;
`endif

    state_e          state_q;
    state_e          state_d;
    logic            flag_q;
    logic            flag_d;
    logic [2:0]      hdr_cnt_q;
    logic [2:0]      hdr_cnt_d;
    logic [15:0]     pix_cnt_q;
    logic [15:0]     pix_cnt_d;
    logic [TW-1:0]   to_cnt_q;
    logic [TW-1:0]   to_cnt_d;
    logic [7:0]      seq_q;
    logic [7:0]      seq_d;
    logic            frame_done_q;
    logic            frame_done_d;
    logic            frame_err_q;
    logic            frame_err_d;
`ifdef CCD_FRAME_CHECKSUM_EN
    logic [7:0]      csum_q;
    logic [7:0]      csum_d;
    logic            csum_take;
`endif

    logic            rise;
    logic            xfer;
    logic            last_pix;
    logic            to_fire;
    logic            slot_load;
    logic [7:0]      slot_din;
    logic [7:0]      hdr_byte;

    assign rise     = serialsend_flag && !flag_q;
    assign xfer     = tx_valid && tx_ready;
    assign last_pix = (pix_cnt_q == PIX_LAST);
    assign to_fire  = (to_cnt_q == TO_LAST);

    byte_tx_slot u_slot (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (slot_load),
        .din   (slot_din),
        .ready (tx_ready),
        .data  (tx_data),
        .valid (tx_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: each sending state advances only when its byte transfers.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rise) state_d = ST_HDR;
            ST_HDR:  if (xfer && hdr_cnt_q == 3'd4) state_d = ST_RD;
            ST_RD: begin
                if (!rdempty)     state_d = ST_LAT;
                else if (to_fire) state_d = ST_PAD;
            end
            ST_LAT:  state_d = ST_SEND;
            ST_SEND: if (xfer) state_d = last_pix ? PAY_NEXT : ST_RD;
            ST_PAD:  if (xfer && last_pix) state_d = PAY_NEXT;
`ifdef CCD_FRAME_CHECKSUM_EN
            ST_CK:   if (xfer) state_d = ST_TR;
`endif
            ST_TR:   if (xfer) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Header byte selected by the header counter.
    always_comb begin
        case (hdr_cnt_q)
            3'd0:    hdr_byte = SYNC0;
            3'd1:    hdr_byte = SYNC1;
            3'd2:    hdr_byte = seq_q;
            3'd3:    hdr_byte = PIX_LEN[15:8];
            default: hdr_byte = PIX_LEN[7:0];
        endcase
    end

    // Outputs: FIFO read strobe, busy and the byte offered to the slot.
    always_comb begin
        rdreq     = 1'b0;
        busy      = (state_q != ST_IDLE);
        slot_load = 1'b0;
        slot_din  = 8'h00;
        unique case (state_q)
            ST_HDR: begin
                slot_load = !tx_valid;
                slot_din  = hdr_byte;
            end
            ST_RD:  rdreq = !rdempty;
            ST_LAT: begin
                slot_load = 1'b1;
                slot_din  = q;
            end
            ST_PAD: begin
                slot_load = !tx_valid;
                slot_din  = 8'h00;
            end
`ifdef CCD_FRAME_CHECKSUM_EN
            ST_CK: begin
                slot_load = !tx_valid;
                slot_din  = csum_q;
            end
`endif
            ST_TR: begin
                slot_load = !tx_valid;
                slot_din  = TRAILER;
            end
            default: ;
        endcase
    end

    // Counters, sequence number, edge detect and status flags.
    always_comb begin
        flag_d       = serialsend_flag;
        hdr_cnt_d    = hdr_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        to_cnt_d     = to_cnt_q;
        seq_d        = seq_q;
        frame_done_d = (state_q == ST_TR) && xfer;
        frame_err_d  = frame_err_q
                     | (rise && state_q != ST_IDLE)
                     | (state_q == ST_RD && rdempty && to_fire);
        if (state_q == ST_IDLE && rise) begin
            hdr_cnt_d = '0;
            pix_cnt_d = '0;
            to_cnt_d  = '0;
        end
        if (state_q == ST_HDR && xfer) hdr_cnt_d = hdr_cnt_q + 3'd1;
        if (state_q == ST_RD) to_cnt_d = rdempty ? to_cnt_q + TW'(1) : '0;
        if ((state_q == ST_SEND || state_q == ST_PAD) && xfer)
            pix_cnt_d = pix_cnt_q + 16'd1;
        if (state_q == ST_TR && xfer) seq_d = seq_q + 8'd1;
    end

`ifdef CCD_FRAME_CHECKSUM_EN
    assign csum_take = (state_q == ST_HDR && hdr_cnt_q >= 3'd2)
                     || state_q == ST_SEND || state_q == ST_PAD;

    // Running sum of seq, length and payload bytes as they transfer.
    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE && rise) csum_d = 8'h00;
        else if (xfer && csum_take)     csum_d = csum_q + tx_data;
    end

    // Checksum register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) csum_q <= 8'h00;
        else        csum_q <= csum_d;
    end
`endif

    // Datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flag_q       <= 1'b0;
            hdr_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            to_cnt_q     <= '0;
            seq_q        <= 8'h00;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            flag_q       <= flag_d;
            hdr_cnt_q    <= hdr_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            to_cnt_q     <= to_cnt_d;
            seq_q        <= seq_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ccd_frame_packetizer.sv
// tb_ccd_frame_packetizer: randomized packet checks against a byte-list model.
// Build with +define+CCD_FRAME_CHECKSUM_EN to cover the checksum variant.
`timescale 1ns/1ps
module tb_ccd_frame_packetizer;

    localparam int PIX = 4;
    localparam int TMO = 8;

    logic       clk;
    logic       n_rst = 1'b0;
    logic       serialsend_flag = 1'b0;
    logic       rdreq;
    logic [7:0] q = 8'h00;
    logic       rdempty;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    ccd_frame_packetizer #(.PIXELS(PIX), .UNDERRUN_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .serialsend_flag (serialsend_flag),
        .rdreq           (rdreq),
        .q               (q),
        .rdempty         (rdempty),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_err       (frame_err)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         underflow = 0;
    logic [7:0] rx_q[$];
    int         xc_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         hold_err = 0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [7:0] exp_seq = 8'h00;
    bit         rand_rdy = 1'b0;
    bit         pat_q[$];
    int         rx_base = 0;
    int         first_v = -1;
    logic       busy1 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Normal-mode FIFO model: data appears the cycle after rdreq.
    assign rdempty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (rdreq) begin
            if (rd_ptr == wr_ptr) underflow <= underflow + 1;
            else begin
                q      <= mem[8'(rd_ptr)];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    // Byte sink: records transfers, done pulses and hold violations.
    always @(negedge clk) begin
        if (n_rst) begin
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                xc_q.push_back(cyc);
            end
            if (frame_done) done_cnt++;
            if (pv && !pr && !(tx_valid && tx_data == pd)) hold_err++;
        end
        pv = tx_valid;
        pr = tx_ready;
        pd = tx_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (pat_q.size() > 0) tx_ready = pat_q.pop_front();
        else if (rand_rdy)    tx_ready = 1'($urandom_range(0, 1));
        else                  tx_ready = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic push_bytes(input int n, input bit inc);
        for (int i = 0; i < n; i++) begin
            mem[8'(wr_ptr)] = inc ? 8'(i + 1) : 8'($urandom);
            wr_ptr++;
        end
    endtask

    // Expected packet from the bytes currently in the FIFO, zero-padded.
    function automatic void build_exp();
        int         sum;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(exp_seq);
        exp_q.push_back(8'(PIX / 256));
        exp_q.push_back(8'(PIX % 256));
        sum = int'(exp_seq) + PIX / 256 + PIX % 256;
        for (int i = 0; i < PIX; i++) begin
            b = (rd_ptr + i < wr_ptr) ? mem[8'(rd_ptr + i)] : 8'h00;
            exp_q.push_back(b);
            sum += int'(b);
        end
`ifdef CCD_FRAME_CHECKSUM_EN
        exp_q.push_back(8'(sum));
`endif
        exp_q.push_back(8'h0A);
    endfunction

    function automatic int first_diff();
        int n;
        n = rx_q.size() - rx_base;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (rx_q[rx_base + i] !== exp_q[i]) return i;
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        return -1;
    endfunction

    task automatic begin_pkt();
        serialsend_flag = 1'b0;
        step();
        build_exp();
        rx_base = rx_q.size();
        serialsend_flag = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int k;
        k = 0;
        first_v = -1;
        busy1 = 1'b0;
        while (done_cnt == d0 && k < 2000) begin
            step();
            k++;
            if (k == 1) busy1 = busy;
            if (first_v < 0 && tx_valid) first_v = k;
        end
        serialsend_flag = 1'b0;
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_done got no frame_done within %0d cycles", nm, k);
        end
    endtask

    task automatic do_packet(input string nm);
        int d0;
        d0 = done_cnt;
        begin_pkt();
        wait_done(nm, d0);
        step();
        step();
        exp_seq++;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        serialsend_flag = 1'b0;
        step();
        step();
        n_rst = 1'b1;
        step();
        exp_seq = 8'h00;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({rdreq, tx_valid, busy, frame_done, frame_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got %b required 00000",
                     {rdreq, tx_valid, busy, frame_done, frame_err});
        end
        checks++;
        if (tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got %h required 00", tx_data);
        end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_basic(input string nm);
        int d0;
        int d;
        push_bytes(PIX, 1'b1);
        d0 = done_cnt;
        do_packet(nm);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL %s_stream idx %0d got_len %0d required_len %0d required %h",
                     nm, d, rx_q.size() - rx_base, exp_q.size(), exp_q[d]);
        end
        checks++;
        if (first_v != 2) begin
            failures++;
            $display("FAIL %s_latency got %0d required 2", nm, first_v);
        end
        checks++;
        if (busy1 !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_entry got %b required 1", nm, busy1);
        end
        if (rx_q.size() >= rx_base + 9) begin
            for (int i = 6; i <= 8; i++) begin
                checks++;
                if (xc_q[rx_base + i] - xc_q[rx_base + i - 1] != 3) begin
                    failures++;
                    $display("FAIL %s_pay_gap%0d got %0d required 3", nm, i,
                             xc_q[rx_base + i] - xc_q[rx_base + i - 1]);
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL %s_done_pulses got %0d required 1", nm, done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle got busy=%b err=%b required 0 0", nm, busy, frame_err);
        end
    endtask

    task automatic test_stall();
        int d0;
        int d;
        push_bytes(PIX, 1'b0);
        d0 = done_cnt;
        begin_pkt();
        pat_q = {1'b1, 1'b0, 1'b0, 1'b1};
        rand_rdy = 1'b1;
        wait_done("stall", d0);
        rand_rdy = 1'b0;
        step();
        step();
        exp_seq++;
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL stall_stream idx %0d got_len %0d required_len %0d",
                     d, rx_q.size() - rx_base, exp_q.size());
        end
        checks++;
        if (hold_err != 0) begin
            failures++;
            $display("FAIL stall_hold got %0d violations required 0", hold_err);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        for (int p = 0; p < 3; p++) begin
            push_bytes(PIX, 1'b0);
            rand_rdy = 1'($urandom_range(0, 1));
            do_packet("b2b");
            d = first_diff();
            checks++;
            if (d >= 0) begin
                failures++;
                $display("FAIL b2b%0d_stream idx %0d got_len %0d required_len %0d",
                         p, d, rx_q.size() - rx_base, exp_q.size());
            end
        end
        rand_rdy = 1'b0;
        checks++;
        if (hold_err != 0) begin
            failures++;
            $display("FAIL b2b_hold got %0d violations required 0", hold_err);
        end
    endtask

    task automatic test_underrun();
        int d;
        push_bytes(2, 1'b0);
        do_packet("underrun");
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL underrun_stream idx %0d got_len %0d required_len %0d",
                     d, rx_q.size() - rx_base, exp_q.size());
        end
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL underrun_err got %b required 1", frame_err);
        end
        checks++;
        if (underflow != 0 || rd_ptr != wr_ptr) begin
            failures++;
            $display("FAIL underrun_reads got underflow=%0d left=%0d required 0 0",
                     underflow, wr_ptr - rd_ptr);
        end
        if (rx_q.size() >= rx_base + 8) begin
            checks++;
            if (xc_q[rx_base + 7] - xc_q[rx_base + 6] < TMO + 1) begin
                failures++;
                $display("FAIL underrun_pad_delay got %0d required >= %0d",
                         xc_q[rx_base + 7] - xc_q[rx_base + 6], TMO + 1);
            end
        end
    endtask

    task automatic test_mid_edge();
        int d0;
        int d;
        int k;
        int n_after;
        do_reset();
        push_bytes(PIX, 1'b0);
        d0 = done_cnt;
        begin_pkt();
        k = 0;
        while (rx_q.size() < rx_base + 6 && k < 500) begin
            step();
            k++;
        end
        serialsend_flag = 1'b0;
        step();
        serialsend_flag = 1'b1;
        wait_done("mid_edge", d0);
        step();
        step();
        exp_seq++;
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL mid_edge_stream idx %0d got_len %0d required_len %0d",
                     d, rx_q.size() - rx_base, exp_q.size());
        end
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL mid_edge_err got %b required 1", frame_err);
        end
        n_after = rx_q.size();
        repeat (40) step();
        checks++;
        if (rx_q.size() != n_after || busy !== 1'b0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL mid_edge_no_second got extra=%0d busy=%b done=%0d required 0 0 1",
                     rx_q.size() - n_after, busy, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int d;
        int k;
        push_bytes(PIX, 1'b0);
        d0 = done_cnt;
        begin_pkt();
        k = 0;
        while (rx_q.size() < rx_base + 7 && k < 500) begin
            step();
            k++;
        end
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({rdreq, tx_valid, busy, frame_done, frame_err} !== 5'b0
            || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_outputs got %b data %h required 00000 data 00",
                     {rdreq, tx_valid, busy, frame_done, frame_err}, tx_data);
        end
        serialsend_flag = 1'b0;
        step();
        step();
        n_rst = 1'b1;
        step();
        exp_seq = 8'h00;
        push_bytes(PIX, 1'b0);
        do_packet("after_reset");
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL after_reset_stream idx %0d got_len %0d required_len %0d",
                     d, rx_q.size() - rx_base, exp_q.size());
        end
        checks++;
        if (frame_err !== 1'b0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL after_reset_status got err=%b done=%0d required 0 1",
                     frame_err, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_basic("second");
        test_stall();
        test_back_to_back();
        test_underrun();
        test_mid_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
